// File: rtl/aes_key_mem.sv
// Round-key generator and store: expands a 128/256-bit cipher key into
// 11 or 15 round keys (one per cycle) and serves them by round index.
module aes_key_mem (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [255:0] key,
    input  logic         keylen,
    input  logic         init,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);

    localparam logic       AES_128_BIT_KEY = 1'h0;
    localparam logic       AES_256_BIT_KEY = 1'h1;
    localparam logic [3:0] AES128_ROUNDS   = 4'ha;
    localparam logic [3:0] AES256_ROUNDS   = 4'he;
    localparam int unsigned NUM_KEYS       = 15;
    localparam int unsigned KEY_W          = 128;

    typedef enum logic {
        CTRL_IDLE,
        CTRL_GENERATE
    } state_t;

    state_t             state_reg;
    state_t             state_new;
    logic [KEY_W-1:0]   key_mem [NUM_KEYS];
    logic [KEY_W-1:0]   prev_key0_reg;
    logic [KEY_W-1:0]   prev_key0_new;
    logic [KEY_W-1:0]   prev_key1_reg;
    logic [KEY_W-1:0]   prev_key1_new;
    logic [3:0]         round_ctr_reg;
    logic [3:0]         round_ctr_new;
    logic [7:0]         rcon_reg;
    logic [7:0]         rcon_new;
    logic               keylen_reg;
    logic               keylen_new;
    logic               ready_reg;
    logic               ready_new;

    logic               mem_we;
    logic [3:0]         mem_addr;
    logic [KEY_W-1:0]   mem_data;

    logic [7:0]         rcon_next;
    logic [31:0]        rot_word;
    logic [31:0]        t_word;
    logic [31:0]        n0;
    logic [31:0]        n1;
    logic [31:0]        n2;
    logic [31:0]        n3;
    logic [KEY_W-1:0]   new_key;
    logic [3:0]         last_round;

    // Datapath for the next round key; chains off prev_key0 in both modes.
    assign rcon_next  = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
    assign rot_word   = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_reg, 24'h0};
    assign t_word     = ((keylen_reg == AES_256_BIT_KEY) && round_ctr_reg[0]) ? new_sboxw : rot_word;
    assign n0         = prev_key0_reg[127:96] ^ t_word;
    assign n1         = prev_key0_reg[95:64]  ^ n0;
    assign n2         = prev_key0_reg[63:32]  ^ n1;
    assign n3         = prev_key0_reg[31:0]   ^ n2;
    assign new_key    = {n0, n1, n2, n3};
    assign last_round = (keylen_reg == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;

    assign ready = ready_reg;

    always_comb begin
        round_key = '0;
        if (round <= AES256_ROUNDS) begin
            round_key = key_mem[round];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_mem[i] <= '0;
            end
            state_reg     <= CTRL_IDLE;
            prev_key0_reg <= '0;
            prev_key1_reg <= '0;
            round_ctr_reg <= '0;
            rcon_reg      <= 8'h01;
            keylen_reg    <= AES_128_BIT_KEY;
            ready_reg     <= 1'b1;
        end else begin
            if (mem_we) begin
                key_mem[mem_addr] <= mem_data;
            end
            state_reg     <= state_new;
            prev_key0_reg <= prev_key0_new;
            prev_key1_reg <= prev_key1_new;
            round_ctr_reg <= round_ctr_new;
            rcon_reg      <= rcon_new;
            keylen_reg    <= keylen_new;
            ready_reg     <= ready_new;
        end
    end

    // Next-state and expansion control.
    always_comb begin
        state_new     = state_reg;
        prev_key0_new = prev_key0_reg;
        prev_key1_new = prev_key1_reg;
        round_ctr_new = round_ctr_reg;
        rcon_new      = rcon_reg;
        keylen_new    = keylen_reg;
        ready_new     = ready_reg;
        mem_we        = 1'b0;
        mem_addr      = round_ctr_reg;
        mem_data      = '0;
        sboxw         = '0;

        case (state_reg)
            CTRL_IDLE: begin
                if (init) begin
                    keylen_new    = keylen;
                    round_ctr_new = '0;
                    rcon_new      = 8'h01;
                    ready_new     = 1'b0;
                    prev_key0_new = key[255:128];
                    prev_key1_new = key[127:0];
                    state_new     = CTRL_GENERATE;
                end
            end

            CTRL_GENERATE: begin
                mem_we        = 1'b1;
                round_ctr_new = round_ctr_reg + 4'(1);
                if (keylen_reg == AES_128_BIT_KEY) begin
                    if (round_ctr_reg == 4'(0)) begin
                        mem_data = prev_key0_reg;
                    end else begin
                        sboxw         = prev_key0_reg[31:0];
                        mem_data      = new_key;
                        prev_key0_new = new_key;
                        rcon_new      = rcon_next;
                    end
                end else begin
                    if (round_ctr_reg == 4'(0)) begin
                        mem_data = prev_key0_reg;
                    end else if (round_ctr_reg == 4'(1)) begin
                        mem_data = prev_key1_reg;
                    end else begin
                        sboxw         = prev_key1_reg[31:0];
                        mem_data      = new_key;
                        prev_key0_new = prev_key1_reg;
                        prev_key1_new = new_key;
                        if (!round_ctr_reg[0]) begin
                            rcon_new = rcon_next;
                        end
                    end
                end
                if (round_ctr_reg == last_round) begin
                    ready_new = 1'b1;
                    state_new = CTRL_IDLE;
                end
            end

            default: begin
                state_new = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_key_mem.sv
// Bench for aes_key_mem: supplies the S-box, models the FIPS-197 key schedule
// and scoreboards every stored round key after each expansion.
module tb_aes_key_mem;

    localparam logic [2047:0] SBOX_P = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [255:0] key;
    logic         keylen;
    logic         init;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] exp;
    } sb_entry_t;

    sb_entry_t    sbq [$];
    logic [127:0] model_keys [15];
    logic [127:0] keys256 [15];
    int           passed = 0;
    int           total  = 0;

    always #5 clk = ~clk;

    aes_key_mem dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key       (key),
        .keylen    (keylen),
        .init      (init),
        .round     (round),
        .round_key (round_key),
        .ready     (ready),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw)
    );

    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [2047:0] tab;
        int idx;
        tab = SBOX_P;
        idx = 2047 - 8 * int'(x);
        return tab[idx -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    assign new_sboxw = sub_word(sboxw);

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    // Word-oriented key schedule in the textbook form.
    task automatic model_expand(input logic [255:0] k, input logic len);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        int nk;
        int nkeys;
        nk    = len ? 8 : 4;
        nkeys = len ? 15 : 11;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4 * nkeys; i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r < nkeys; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic push_expected(input logic len);
        int nkeys;
        sb_entry_t e;
        nkeys = len ? 15 : 11;
        for (int r = 0; r < nkeys; r++) begin
            e.idx = 4'(r);
            e.exp = model_keys[r];
            sbq.push_back(e);
        end
    endtask

    task automatic read_key(input logic [3:0] r, output logic [127:0] v);
        @(negedge clk);
        round = r;
        #1;
        v = round_key;
    endtask

    task automatic drain(input string tag);
        sb_entry_t    e;
        logic [127:0] v;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            read_key(e.idx, v);
            check($sformatf("%s_key%0d", tag, e.idx), v, e.exp);
        end
    endtask

    // Drive init for exactly one sampled edge, then scramble key/keylen.
    task automatic start_init(input logic [255:0] k, input logic len, output logic [31:0] sb0);
        @(negedge clk);
        key    = k;
        keylen = len;
        init   = 1'b1;
        model_expand(k, len);
        push_expected(len);
        @(posedge clk);
        #1;
        init   = 1'b0;
        key    = {8{$urandom()}};
        keylen = ~len;
        sb0    = sboxw;
    endtask

    task automatic wait_ready(input int busy_at, output int lat, output logic rdy1,
                              output logic [31:0] sb1, output logic [31:0] sb2);
        lat  = -1;
        rdy1 = 1'bx;
        sb1  = 'x;
        sb2  = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            init = (c == busy_at);
            if (c == 1) begin
                rdy1 = ready;
                sb1  = sboxw;
            end
            if (c == 2) sb2 = sboxw;
            if (ready) begin
                lat = c;
                break;
            end
        end
        init = 1'b0;
    endtask

    int           lat;
    logic         rdy1;
    logic [31:0]  sb0;
    logic [31:0]  sb1;
    logic [31:0]  sb2;
    logic [127:0] v;

    initial begin
        reset_n = 1'b0;
        init    = 1'b0;
        key     = '0;
        keylen  = 1'b0;
        round   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        #1;
        check("rst_ready", 128'(ready), 128'(1));
        check("rst_sboxw", 128'(sboxw), 128'(0));
        for (int r = 0; r < 16; r++) begin
            read_key(4'(r), v);
            check($sformatf("rst_key%0d", r), v, 128'h0);
        end

        // AES-128 expansion
        start_init(K128, 1'b0, sb0);
        wait_ready(0, lat, rdy1, sb1, sb2);
        check("a128_latency", 128'(lat), 128'(11));
        check("a128_busy", 128'(rdy1), 128'(0));
        check("a128_sbox_r0", 128'(sb0), 128'(0));
        check("a128_sbox_r1", 128'(sb1), 128'(32'h09cf4f3c));
        drain("a128");
        read_key(4'd1, v);
        check("a128_vec_r1", v, 128'ha0fafe1788542cb123a339392a6c7605);
        read_key(4'd10, v);
        check("a128_vec_r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-256 expansion
        start_init(K256, 1'b1, sb0);
        wait_ready(0, lat, rdy1, sb1, sb2);
        check("a256_latency", 128'(lat), 128'(15));
        check("a256_busy", 128'(rdy1), 128'(0));
        check("a256_sbox_r1", 128'(sb1), 128'(0));
        check("a256_sbox_r2", 128'(sb2), 128'(32'h0914dff4));
        drain("a256");
        read_key(4'd2, v);
        check("a256_vec_r2", v, 128'h9ba354118e6925afa51a8b5f2067fcde);
        read_key(4'd14, v);
        check("a256_vec_r14", v, 128'hfe4890d1e6188d0b046df344706c631e);
        read_key(4'd15, v);
        check("a256_r15_zero", v, 128'h0);

        // Second init while busy is ignored
        start_init(K128, 1'b0, sb0);
        wait_ready(3, lat, rdy1, sb1, sb2);
        check("busy_latency", 128'(lat), 128'(11));
        drain("busy");

        // Reset in the middle of an AES-256 run
        start_init(K256, 1'b1, sb0);
        sbq.delete();
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("mid_rst_ready", 128'(ready), 128'(1));
        check("mid_rst_sboxw", 128'(sboxw), 128'(0));
        for (int r = 0; r < 15; r++) begin
            read_key(4'(r), v);
            check($sformatf("mid_rst_key%0d", r), v, 128'h0);
        end
        start_init(K128, 1'b0, sb0);
        wait_ready(0, lat, rdy1, sb1, sb2);
        check("post_rst_latency", 128'(lat), 128'(11));
        drain("post_rst");

        // Back-to-back AES-256 then AES-128; upper keys stay stale
        start_init(K256, 1'b1, sb0);
        for (int r = 0; r < 15; r++) keys256[r] = model_keys[r];
        wait_ready(0, lat, rdy1, sb1, sb2);
        check("b2b_256_latency", 128'(lat), 128'(15));
        drain("b2b_256");
        start_init(K128, 1'b0, sb0);
        wait_ready(0, lat, rdy1, sb1, sb2);
        check("b2b_128_latency", 128'(lat), 128'(11));
        drain("b2b_128");
        read_key(4'd10, v);
        check("b2b_vec_r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        for (int r = 11; r < 15; r++) begin
            read_key(4'(r), v);
            check($sformatf("b2b_stale_key%0d", r), v, keys256[r]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed %0d/%0d checks", passed, total);
        $fatal(1, "watchdog expired");
    end

endmodule
